alu_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single 32-bit MIPS ALU between two requesters, e.g. the execute stage and a branch-target/address unit. It accepts one operation at a time over a valid/ready handshake and drives the shared ALU from registered operands. It returns the registered result to the granted requester over a second valid/ready handshake. The block instantiates the ALU internally, so nothing else in the design drives the ALU.

---
 rtl/alu_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit MIPS ALU between two requesters with valid/ready
// request and response handshakes. Define ALU_ARB_FIXED_PRIO_EN for fixed priority.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              owner_q, owner_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              grant0_s, grant1_s;
  logic [DATA_W-1:0] alu_y_s;

  function automatic logic [DATA_W-1:0] alu_eval(input logic [2:0]        op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] y;
    case (op)
      3'b000:  y = a & b;
      3'b001:  y = a | b;
      3'b010:  y = a + b;
      3'b110:  y = a - b;
      3'b111:  y = {{(DATA_W-1){1'b0}}, (a < b)};
      default: y = {DATA_W{1'b0}};
    endcase
    return y;
  endfunction

  // Shared ALU, driven only from the latched operation fields
  always_comb begin
    alu_y_s = alu_eval(op_q, a_q, b_q);
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Grant: requester 0 wins every tie
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_q == ST_IDLE) begin
      grant0_s = req0_valid;
      grant1_s = req1_valid & ~req0_valid;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end
`else
  logic last_grant_q, last_grant_d;

  // Grant: round-robin on a tie, the requester not granted last time wins
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_q != ST_IDLE) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      grant0_s = last_grant_q;
      grant1_s = ~last_grant_q;
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
  end

  // Round-robin pointer follows each accept
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant1_s) begin
      last_grant_d = 1'b1;
    end else if (grant0_s) begin
      last_grant_d = 1'b0;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Reset to 1 so requester 0 takes the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Sequencer: IDLE accepts, EXEC registers the ALU result, RESP waits for the owner
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    owner_d      = owner_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0_s || grant1_s) begin
          op_d    = grant1_s ? req1_op : req0_op;
          a_d     = grant1_s ? req1_a  : req0_a;
          b_d     = grant1_s ? req1_b  : req0_b;
          owner_d = grant1_s;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_data_d   = alu_y_s;
        rsp0_valid_d = ~owner_q;
        rsp1_valid_d = owner_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if ((!owner_q && rsp0_ready) || (owner_q && rsp1_ready)) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= 3'b000;
      a_q          <= {DATA_W{1'b0}};
      b_q          <= {DATA_W{1'b0}};
      owner_q      <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_data_q   <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      owner_q      <= owner_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed stimulus against a transaction-level
// reference model (pending op with an age counter, round-robin/fixed tie rule).
module tb_alu_arbiter;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data)
  );

  // stimulus state
  op_t q0[$], q1[$];
  op_t cur0, cur1;
  bit  hold0, hold1;
  int  gate_pct = 100, rdy_pct0 = 100, rdy_pct1 = 100;

  // reference model: at most one op in flight, aged in cycles since accept
  bit          m_busy, m_owner, m_last;
  int          m_age;
  logic [31:0] m_res, m_data;
  int          edge_n;
  int          log_port[$], log_edge[$], acc_port[$], acc_edge[$];
  logic [31:0] log_data[$];

  int n_cmp = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input op_t o);
    case (o.op)
      3'b000:  return o.a & o.b;
      3'b001:  return o.a | o.b;
      3'b010:  return o.a + o.b;
      3'b110:  return o.a - o.b;
      3'b111:  return (o.a < o.b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic op_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.op = op; o.a = a; o.b = b;
    return o;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'd0;
      2:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  function automatic bit exp_grant(input int k);
    if (m_busy) return 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    return (k == 0) ? req0_valid : (req1_valid && !req0_valid);
`else
    if (req0_valid && req1_valid) return (k == 0) ? m_last : !m_last;
    return (k == 0) ? req0_valid : req1_valid;
`endif
  endfunction

  function automatic void model_reset();
    m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_age = 0;
    m_res = 32'd0; m_data = 32'd0;
    hold0 = 1'b0; hold1 = 1'b0;
    q0.delete(); q1.delete();
  endfunction

  // one clock: drive at negedge, check 1 ns later, advance model at posedge
  task automatic step();
    bit g0, g1;
    @(negedge clk);
    if (!hold0) begin
      if (q0.size() > 0 && $urandom_range(0, 99) < gate_pct) begin
        cur0 = q0.pop_front(); req0_valid = 1'b1;
      end else req0_valid = 1'b0;
    end
    if (!hold1) begin
      if (q1.size() > 0 && $urandom_range(0, 99) < gate_pct) begin
        cur1 = q1.pop_front(); req1_valid = 1'b1;
      end else req1_valid = 1'b0;
    end
    req0_op = cur0.op; req0_a = cur0.a; req0_b = cur0.b;
    req1_op = cur1.op; req1_a = cur1.a; req1_b = cur1.b;
    rsp0_ready = ($urandom_range(0, 99) < rdy_pct0);
    rsp1_ready = ($urandom_range(0, 99) < rdy_pct1);
    #1;
    g0 = exp_grant(0);
    g1 = exp_grant(1);
    check_eq("req0_ready", req0_ready, g0);
    check_eq("req1_ready", req1_ready, g1);
    check_eq("rsp0_valid", rsp0_valid, m_busy && m_age == 2 && !m_owner);
    check_eq("rsp1_valid", rsp1_valid, m_busy && m_age == 2 && m_owner);
    check_eq("rsp_data", rsp_data, m_data);
    @(posedge clk);
    edge_n++;
    if (m_busy) begin
      if (m_age == 1) begin
        m_age = 2; m_data = m_res;
      end else if ((!m_owner && rsp0_ready) || (m_owner && rsp1_ready)) begin
        m_busy = 1'b0;
        log_port.push_back(int'(m_owner)); log_data.push_back(m_data); log_edge.push_back(edge_n);
      end
    end else if (g0 || g1) begin
      m_busy = 1'b1; m_age = 1; m_owner = g1; m_last = g1;
      m_res = g1 ? ref_alu(cur1) : ref_alu(cur0);
      acc_port.push_back(int'(g1)); acc_edge.push_back(edge_n);
    end
    hold0 = req0_valid && !g0;
    hold1 = req1_valid && !g1;
  endtask

  task automatic run_idle(input int budget, input string tag);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || hold0 || hold1 || m_busy) && n < budget) begin
      step(); n++;
    end
    check_eq({tag, "_drained"}, (q0.size() > 0 || q1.size() > 0 || hold0 || hold1 || m_busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    model_reset();
    #1;
    check_eq("rst_rsp0_valid", rsp0_valid, 0);
    check_eq("rst_rsp1_valid", rsp1_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 32'd0);
    check_eq("rst_req0_ready", req0_ready, 0);
    check_eq("rst_req1_ready", req1_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, n, rsp1_edge, acc0_edge;
    logic [31:0] exp_edge [5];
    exp_edge[0] = 32'hFFFF_FFFF; exp_edge[1] = 32'h0; exp_edge[2] = 32'h1;
    exp_edge[3] = 32'h0;         exp_edge[4] = 32'h0;
    edge_n = 0;
    cur0 = mk(3'd0, 32'd0, 32'd0);
    cur1 = mk(3'd0, 32'd0, 32'd0);
    do_reset();

    // single ADD
    q0.push_back(mk(3'b010, 32'd5, 32'd3));
    run_idle(20, "add");
    check_eq("add_port", log_port[log_port.size()-1], 0);
    check_eq("add_data", log_data[log_data.size()-1], 32'd8);
    check_eq("add_latency", log_edge[log_edge.size()-1] - acc_edge[acc_edge.size()-1], 2);

    // arithmetic edges
    base = log_data.size();
    q0.push_back(mk(3'b110, 32'd0, 32'd1));
    q0.push_back(mk(3'b010, 32'hFFFF_FFFF, 32'd1));
    q0.push_back(mk(3'b111, 32'd1, 32'hFFFF_FFFF));
    q0.push_back(mk(3'b111, 32'hFFFF_FFFF, 32'd1));
    q0.push_back(mk(3'b100, 32'h1234_5678, 32'h9ABC_DEF0));
    run_idle(60, "edges");
    for (int i = 0; i < 5; i++) check_eq($sformatf("edge_%0d", i), log_data[base+i], exp_edge[i]);

    // contention from reset, both always valid
    do_reset();
    base = log_port.size();
    n = acc_edge.size();
    q0.push_back(mk(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF));
    q0.push_back(mk(3'b001, 32'h0000_00A0, 32'h0000_000B));
    q0.push_back(mk(3'b010, 32'd100, 32'd23));
    q0.push_back(mk(3'b110, 32'd50, 32'd8));
    q1.push_back(mk(3'b111, 32'd2, 32'd9));
    q1.push_back(mk(3'b010, 32'd7, 32'd7));
    q1.push_back(mk(3'b001, 32'h1, 32'h2));
    q1.push_back(mk(3'b000, 32'hFF, 32'h0F));
    run_idle(100, "contend");
    for (int i = 0; i < 8; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      check_eq($sformatf("contend_port_%0d", i), log_port[base+i], (i < 4) ? 0 : 1);
`else
      check_eq($sformatf("contend_port_%0d", i), log_port[base+i], i % 2);
`endif
    end
    for (int i = 0; i < 7; i++)
      check_eq($sformatf("contend_period_%0d", i), acc_edge[n+i+1] - acc_edge[n+i], 3);

    // backpressure on requester 1 with requester 0 waiting
    rdy_pct1 = 0;
    q1.push_back(mk(3'b001, 32'h0000_00A0, 32'h0000_000B));
    n = 0;
    while (!(m_busy && m_age == 2) && n < 10) begin step(); n++; end
    q0.push_back(mk(3'b010, 32'd7, 32'd9));
    for (int i = 0; i < 5; i++) begin
      step();
      #2;
      check_eq("bp_data", rsp_data, 32'h0000_00AB);
      check_eq("bp_rsp1_valid", rsp1_valid, 1);
      check_eq("bp_req0_ready", req0_ready, 0);
    end
    rdy_pct1 = 100;
    run_idle(30, "bp");
    rsp1_edge = -100;
    acc0_edge = -200;
    for (int i = 0; i < log_port.size(); i++) if (log_port[i] == 1) rsp1_edge = log_edge[i];
    for (int i = 0; i < acc_port.size(); i++) if (acc_port[i] == 0) acc0_edge = acc_edge[i];
    check_eq("bp_next_accept", acc0_edge - rsp1_edge, 1);
    check_eq("bp_req0_data", log_data[log_data.size()-1], 32'd16);

    // reset during EXEC
    q0.push_back(mk(3'b010, 32'h100, 32'h200));
    n = 0;
    while (!(m_busy && m_age == 1) && n < 10) begin step(); n++; end
    #2;
    check_eq("pre_rst_data", rsp_data, 32'd16);
    do_reset();
    base = log_port.size();
    q0.push_back(mk(3'b000, 32'hFF, 32'h3C));
    q1.push_back(mk(3'b010, 32'd1, 32'd2));
    run_idle(30, "post_rst");
    check_eq("post_rst_first_port", log_port[base], 0);
    check_eq("post_rst_no_replay", log_port.size() - base, 2);

    // randomized traffic
    gate_pct = 60; rdy_pct0 = 70; rdy_pct1 = 70;
    base = log_port.size();
    for (int i = 0; i < 80; i++) begin
      q0.push_back(mk(3'($urandom_range(0, 7)), rand_word(), rand_word()));
      q1.push_back(mk(3'($urandom_range(0, 7)), rand_word(), rand_word()));
    end
    run_idle(4000, "random");
    check_eq("random_count", log_port.size() - base, 160);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
